// File: rtl/wb_stage_pkg.sv
// Shared types and constants for the MEM/WB writeback stage.
package wb_stage_pkg;

  typedef logic [4:0] regIdx_t;

  localparam regIdx_t REG_ZERO = '0;

  typedef enum logic [2:0] {
    LD_W  = 3'd0,
    LD_B  = 3'd1,
    LD_BU = 3'd2,
    LD_H  = 3'd3,
    LD_HU = 3'd4
  } loadType_t;

endpackage

// File: rtl/load_align.sv
// Big-endian sub-word load selection with sign/zero extension.
module load_align
  import wb_stage_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  offset,
  input  logic [2:0]  loadType,
  output logic [31:0] result
);

  logic [7:0]  byteSel;
  logic [15:0] halfSel;

  always_comb begin
    byteSel = word[31:24];
    case (offset)
      2'd0: byteSel = word[31:24];
      2'd1: byteSel = word[23:16];
      2'd2: byteSel = word[15:8];
      2'd3: byteSel = word[7:0];
      default: byteSel = word[31:24];
    endcase
    halfSel = offset[1] ? word[15:0] : word[31:16];
  end

  // Encodings 5-7 fall to the default and behave as a full-word load.
  always_comb begin
    result = word;
    case (loadType)
      LD_B:    result = {{24{byteSel[7]}}, byteSel};
      LD_BU:   result = {24'h0, byteSel};
      LD_H:    result = {{16{halfSel[15]}}, halfSel};
      LD_HU:   result = {16'h0, halfSel};
      default: result = word;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// MEM/WB pipeline register driving the register file write port, with
// write-through read bypass and a retired-entry counter.
module wb_stage
  import wb_stage_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Flush,
  input  logic             InValid,
  input  logic             InRegWrite,
  input  logic             InMemToReg,
  input  logic [2:0]       InLoadType,
  input  logic [4:0]       InWriteRegister,
  input  logic [31:0]      InAluResult,
  input  logic [31:0]      InMemData,
  input  logic [4:0]       ReadRegister1,
  input  logic [4:0]       ReadRegister2,
  input  logic [31:0]      RfReadData1,
  input  logic [31:0]      RfReadData2,
  output logic [31:0]      WriteData,
  output logic [4:0]       WriteRegister,
  output logic             RegWrite,
  output logic [31:0]      ReadData1,
  output logic [31:0]      ReadData2,
  output logic [CNT_W-1:0] RetireCount
);

  logic        validQ;
  logic        regWriteQ;
  regIdx_t     writeRegQ;
  logic [31:0] writeDataQ;
  logic [31:0] alignedData;
  logic [31:0] writeDataD;

  load_align uAlign (
    .word     (InMemData),
    .offset   (InAluResult[1:0]),
    .loadType (InLoadType),
    .result   (alignedData)
  );

  assign writeDataD = InMemToReg ? alignedData : InAluResult;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      validQ      <= 1'b0;
      regWriteQ   <= 1'b0;
      writeRegQ   <= REG_ZERO;
      writeDataQ  <= '0;
      RetireCount <= '0;
    end else begin
      // Count the entry being retired now, before it is overwritten.
      if (validQ) RetireCount <= RetireCount + 1'b1;
      validQ     <= InValid & ~Flush;
      regWriteQ  <= InRegWrite;
      writeRegQ  <= InWriteRegister;
      writeDataQ <= writeDataD;
    end
  end

  assign RegWrite      = validQ & regWriteQ & (writeRegQ != REG_ZERO);
  assign WriteRegister = writeRegQ;
  assign WriteData     = writeDataQ;

  // RegWrite already excludes register 0, so a read of 0 never bypasses.
  always_comb begin
    ReadData1 = RfReadData1;
    ReadData2 = RfReadData2;
    if (RegWrite && (writeRegQ == ReadRegister1)) ReadData1 = writeDataQ;
    if (RegWrite && (writeRegQ == ReadRegister2)) ReadData2 = writeDataQ;
  end

endmodule

// File: tb/tb_wb_stage.sv
// Randomized bench for wb_stage against a behavioural writeback model.
module tb_wb_stage;

  localparam int unsigned CNT_W = 32;

  logic             Clk = 1'b0;
  logic             Reset;
  logic             Flush;
  logic             InValid;
  logic             InRegWrite;
  logic             InMemToReg;
  logic [2:0]       InLoadType;
  logic [4:0]       InWriteRegister;
  logic [31:0]      InAluResult;
  logic [31:0]      InMemData;
  logic [4:0]       ReadRegister1;
  logic [4:0]       ReadRegister2;
  logic [31:0]      RfReadData1;
  logic [31:0]      RfReadData2;
  logic [31:0]      WriteData;
  logic [4:0]       WriteRegister;
  logic             RegWrite;
  logic [31:0]      ReadData1;
  logic [31:0]      ReadData2;
  logic [CNT_W-1:0] RetireCount;

  wb_stage #(.CNT_W(CNT_W)) dut (
    .Clk             (Clk),
    .Reset           (Reset),
    .Flush           (Flush),
    .InValid         (InValid),
    .InRegWrite      (InRegWrite),
    .InMemToReg      (InMemToReg),
    .InLoadType      (InLoadType),
    .InWriteRegister (InWriteRegister),
    .InAluResult     (InAluResult),
    .InMemData       (InMemData),
    .ReadRegister1   (ReadRegister1),
    .ReadRegister2   (ReadRegister2),
    .RfReadData1     (RfReadData1),
    .RfReadData2     (RfReadData2),
    .WriteData       (WriteData),
    .WriteRegister   (WriteRegister),
    .RegWrite        (RegWrite),
    .ReadData1       (ReadData1),
    .ReadData2       (ReadData2),
    .RetireCount     (RetireCount)
  );

  always #5 Clk = ~Clk;

  int unsigned nChecks = 0;
  int unsigned nFails  = 0;

  // Model of the entry currently held in the stage.
  bit               mValid;
  bit               mRegWr;
  logic [4:0]       mWreg;
  logic [31:0]      mWdata;
  logic [CNT_W-1:0] mCount;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    if (obs !== exp) begin
      nFails++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] refAlign(input bit m2r, input int unsigned lt,
                                           input logic [31:0] alu, input logic [31:0] mem);
    int unsigned off, b, h;
    if (!m2r) return alu;
    off = alu % 4;
    case (lt)
      1, 2: begin
        b = (mem >> (24 - 8 * off)) & 32'hFF;
        if (lt == 1 && b >= 128) return b + 32'hFFFFFF00;
        return b;
      end
      3, 4: begin
        h = (mem >> ((off >= 2) ? 0 : 16)) & 32'hFFFF;
        if (lt == 3 && h >= 32768) return h + 32'hFFFF0000;
        return h;
      end
      default: return mem;
    endcase
  endfunction

  function automatic bit expRegWrite();
    return mValid && mRegWr && (mWreg != 5'd0);
  endfunction

  task automatic modelReset();
    mValid = 0; mRegWr = 0; mWreg = '0; mWdata = '0; mCount = '0;
  endtask

  task automatic setIn(input bit v, input bit rw, input bit m2r, input logic [2:0] lt,
                       input logic [4:0] wreg, input logic [31:0] alu,
                       input logic [31:0] mem, input bit fl);
    InValid = v; InRegWrite = rw; InMemToReg = m2r; InLoadType = lt;
    InWriteRegister = wreg; InAluResult = alu; InMemData = mem; Flush = fl;
  endtask

  // Register file emulation: register 0 always reads as zero.
  task automatic checkBypass(input logic [4:0] rr1, input logic [4:0] rr2,
                             input logic [31:0] r1, input logic [31:0] r2);
    logic [31:0] e1, e2;
    ReadRegister1 = rr1;
    ReadRegister2 = rr2;
    RfReadData1   = (rr1 == 0) ? 32'h0 : r1;
    RfReadData2   = (rr2 == 0) ? 32'h0 : r2;
    e1 = (expRegWrite() && mWreg == rr1) ? mWdata : RfReadData1;
    e2 = (expRegWrite() && mWreg == rr2) ? mWdata : RfReadData2;
    #1;
    check("ReadData1", ReadData1, e1);
    check("ReadData2", ReadData2, e2);
  endtask

  task automatic checkHeld();
    check("RegWrite", {31'h0, RegWrite}, {31'h0, expRegWrite()});
    if (expRegWrite()) begin
      check("WriteRegister", {27'h0, WriteRegister}, {27'h0, mWreg});
      check("WriteData", WriteData, mWdata);
    end
    check("RetireCount", RetireCount, mCount);
  endtask

  task automatic cycle();
    logic [4:0] rr1, rr2;
    @(posedge Clk);
    if (mValid) mCount++;
    mValid = InValid && !Flush;
    mRegWr = InRegWrite;
    mWreg  = InWriteRegister;
    mWdata = refAlign(InMemToReg, InLoadType, InAluResult, InMemData);
    #1;
    checkHeld();
    rr1 = ($urandom_range(1) != 0) ? mWreg : 5'($urandom);
    rr2 = ($urandom_range(1) != 0) ? mWreg : 5'($urandom);
    checkBypass(rr1, rr2, $urandom, $urandom);
  endtask

  logic [2:0]  ldType [7] = '{3'd1, 3'd2, 3'd1, 3'd3, 3'd4, 3'd3, 3'd6};
  logic [31:0] ldOff  [7] = '{32'd0, 32'd0, 32'd2, 32'd2, 32'd0, 32'd0, 32'd0};
  logic [31:0] ldExp  [7] = '{32'hFFFFFF80, 32'h00000080, 32'h0000007F, 32'h00007F01,
                              32'h000080FF, 32'hFFFF80FF, 32'h80FF7F01};

  initial begin
    logic [CNT_W-1:0] savedCount;
    Reset = 1'b1;
    setIn(0, 0, 0, 3'd0, 5'd0, 32'h0, 32'h0, 0);
    ReadRegister1 = '0; ReadRegister2 = '0; RfReadData1 = '0; RfReadData2 = '0;
    modelReset();

    // Reset state and passthrough
    #12;
    check("rstRegWrite", {31'h0, RegWrite}, 32'h0);
    check("rstWriteRegister", {27'h0, WriteRegister}, 32'h0);
    check("rstWriteData", WriteData, 32'h0);
    check("rstRetireCount", RetireCount, 32'h0);
    checkBypass(5'd4, 5'd7, 32'h01020304, 32'hA5A5A5A5);
    @(negedge Clk);
    Reset = 1'b0;

    // First ALU writeback
    setIn(1, 1, 0, 3'd0, 5'd5, 32'h12345678, 32'h0, 0);
    cycle();
    check("firstRegWrite", {31'h0, RegWrite}, 32'h1);
    check("firstWriteData", WriteData, 32'h12345678);
    setIn(0, 0, 0, 3'd0, 5'd0, 32'h0, 32'h0, 0);
    cycle();
    check("firstRetire", RetireCount, 32'h1);

    // Load alignment table
    for (int i = 0; i < 7; i++) begin
      setIn(1, 1, 1, ldType[i], 5'd10, 32'h00001000 + ldOff[i], 32'h80FF7F01, 0);
      cycle();
      check($sformatf("load%0d", i), WriteData, ldExp[i]);
    end

    // Write to register 0 is suppressed but still retires
    savedCount = mCount;
    setIn(1, 1, 0, 3'd0, 5'd0, 32'hDEADBEEF, 32'h0, 0);
    cycle();
    check("r0RegWrite", {31'h0, RegWrite}, 32'h0);
    checkBypass(5'd0, 5'd0, 32'h0, 32'h0);
    check("r0Read", ReadData1, 32'h0);
    setIn(0, 0, 0, 3'd0, 5'd0, 32'h0, 32'h0, 0);
    cycle();
    check("r0Retire", RetireCount, savedCount + 2);

    // Dual bypass of register 7
    setIn(1, 1, 0, 3'd0, 5'd7, 32'hCAFEF00D, 32'h0, 0);
    cycle();
    checkBypass(5'd7, 5'd7, 32'h11111111, 32'h11111111);
    check("bypass1", ReadData1, 32'hCAFEF00D);
    check("bypass2", ReadData2, 32'hCAFEF00D);
    checkBypass(5'd7, 5'd8, 32'h11111111, 32'h11111111);
    check("noBypass2", ReadData2, 32'h11111111);

    // Flush turns a valid write into a bubble
    setIn(1, 1, 0, 3'd0, 5'd9, 32'h99999999, 32'h0, 1);
    cycle();
    check("flushRegWrite", {31'h0, RegWrite}, 32'h0);
    savedCount = RetireCount;
    setIn(0, 0, 0, 3'd0, 5'd0, 32'h0, 32'h0, 0);
    cycle();
    check("flushRetire", RetireCount, savedCount);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      setIn($urandom_range(3) != 0, $urandom_range(3) != 0, $urandom_range(1) != 0,
            3'($urandom), 5'($urandom_range(7)), $urandom, $urandom, $urandom_range(7) == 0);
      cycle();
    end

    // Asynchronous reset while a valid write is held
    setIn(1, 1, 0, 3'd0, 5'd3, 32'h33333333, 32'h0, 0);
    cycle();
    check("preRstRegWrite", {31'h0, RegWrite}, 32'h1);
    #2;
    Reset = 1'b1;
    modelReset();
    #1;
    check("asyncRegWrite", {31'h0, RegWrite}, 32'h0);
    check("asyncRetire", RetireCount, 32'h0);
    @(posedge Clk);
    #1;
    check("heldRstRegWrite", {31'h0, RegWrite}, 32'h0);
    @(negedge Clk);
    Reset = 1'b0;

    for (int i = 0; i < 100; i++) begin
      setIn($urandom_range(3) != 0, $urandom_range(3) != 0, $urandom_range(1) != 0,
            3'($urandom), 5'($urandom_range(7)), $urandom, $urandom, $urandom_range(7) == 0);
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
